excl_grant_arbiter: RTL
=======================

Name: excl_grant_arbiter

Overview:
- Three-requester round-robin arbiter; drives at most one of three grant lines high in any cycle.
- It is the driving end of the mutually-exclusive three-line interface that our protocol assertion monitors check.
- A grant is held until the owner releases it or a hold watchdog expires.
- Sits between shared-resource requesters (e.g. bus-port or debug-access owners) and the resource mux select.

Parameters:
- MAX_HOLD, 64, max cycles a grant may be held before forced revocation; legal range 2..65535.
- GAP_CYCLES, 1, idle cycles between revoking one grant and issuing the next; legal range 0..15.
- CNT_W, 16, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  per-requester request level; bit i = requester i.
- release  in  3  per-requester one-cycle release pulse; only honoured from the current owner.
- grant  out  3  one-hot-or-zero grant; never more than one bit set.
- owner  out  2  index of current owner; 2'd3 when no grant.
- busy  out  1  high in GRANT or GAP.
- timeout  out  1  one-cycle pulse when the watchdog revokes a grant.
- err_release  out  1  one-cycle pulse when release arrives from a non-owner or while idle.

Behaviour:
- Reset (async assert, sync deassert): grant=0, owner=3, busy=0, timeout=0, err_release=0, rr_ptr=0, hold_cnt=0, gap_cnt=0, state=IDLE.
- State machine has three states: IDLE, GRANT, GAP.
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr upward, mod 3.
  - Register grant=onehot(sel) and owner=sel; go to GRANT. Grant is visible the cycle after req is sampled (latency 1).
  - If no req bit is set, stay in IDLE.
- GRANT:
  - hold_cnt increments every cycle, starting at 0 on entry.
  - If release[owner]=1, drop grant to 0 on the next edge and set rr_ptr=(owner+1) mod 3.
  - Else if hold_cnt==MAX_HOLD-1, drop grant, pulse timeout for one cycle, and set rr_ptr=(owner+1) mod 3.
  - On either exit, go to GAP if GAP_CYCLES>0, otherwise go directly to IDLE.
  - A release and the watchdog hitting in the same cycle counts as a release: timeout stays 0.
  - Deasserting req[owner] without a release does not revoke the grant; only release or the watchdog ends it.
- GAP:
  - grant=0, owner=3; gap_cnt counts GAP_CYCLES cycles, then go to IDLE.
  - Requests are ignored during GAP.
- GAP_CYCLES=0 path: IDLE is re-entered and can grant on the following edge, so there is at least one zero-grant cycle between owners. grant never switches directly from one owner to another.
- err_release:
  - Pulses for any release bit that is set where the bit is not owner, or where state is not GRANT.
  - Has no other effect. A legal and an illegal release bit in the same cycle: the legal one is honoured and err_release still pulses.
- Wrap-around: rr_ptr modulo 3; value 3 is never stored. The hold counter saturates and never wraps.
- Reset mid-GRANT: grant clears asynchronously; no timeout pulse is generated.
- Invariant: grant is one-hot or zero in every cycle, and grant==0 whenever reset=1.

Decomposition:
- Shared package excl_arb_pkg:
  - state enum {IDLE, GRANT, GAP}
  - NUM_REQ=3
  - NO_OWNER=2'd3
  - function rr_pick(req, ptr) returning index plus a valid flag.
- One natural sub-module: excl_arb_rr_pick, a combinational rotate-priority encoder instantiated once. All state lives in the top.

Test Plan:
- Basic grant: req=3'b010 from idle with rr_ptr=0 -> grant=3'b010 and owner=1 after 1 cycle. Then release=3'b010 -> grant=0 next cycle, GAP for 1 cycle, rr_ptr=2.
- Round-robin fairness: req=3'b111 held constantly, each owner releasing after 3 cycles -> owner sequence 0,1,2,0. Each grant lasts 3 cycles, separated by 1 zero cycle (GAP_CYCLES=1).
- Watchdog: MAX_HOLD=8, req=3'b001, never release -> grant held 8 cycles, then grant=0 and one timeout pulse; next owner search starts from 1.
- Simultaneous events: release[owner] in the same cycle hold_cnt reaches MAX_HOLD-1 -> timeout=0, normal release. Also release=3'b100 while owner=0 -> err_release=1 and grant unchanged.
- Reset mid-grant: assert reset asynchronously between edges while grant=3'b100 -> grant=0 immediately, owner=3, rr_ptr=0. After deassert with req=3'b100 -> regrant after 1 cycle.
- Random stress: 10k cycles of random req/release, GAP_CYCLES in {0,1,3} -> the mutual-exclusion monitor reports no violation, and no grant is ever held beyond MAX_HOLD cycles.

Source files
------------

// File: rtl/excl_arb_pkg.sv
// Shared types and helpers for the three-requester exclusive-grant arbiter.
// Owner indices are 2 bits wide; the value 3 is reserved to mean "no owner".
package excl_arb_pkg;

    localparam int         NUM_REQ  = 3;
    localparam logic [1:0] NO_OWNER = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, wrapping modulo NUM_REQ.
    // Walking the offsets downward lets the lowest offset win.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         ptr);
        rr_pick_t   p;
        logic [2:0] s;
        p.valid = 1'b0;
        p.idx   = NO_OWNER;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + 3'(k);
            if (s >= 3'd3) s = s - 3'd3;
            if (req[s[1:0]]) begin
                p.valid = 1'b1;
                p.idx   = s[1:0];
            end
        end
        return p;
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        if (idx != NO_OWNER) oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/excl_arb_rr_pick.sv
// Combinational rotate-priority encoder: picks the first active request
// starting from the round-robin pointer.
module excl_arb_rr_pick
    import excl_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic               valid_o,
    output logic [1:0]         idx_o
);

    rr_pick_t pick;

    assign pick    = rr_pick(req_i, ptr_i);
    assign valid_o = pick.valid;
    assign idx_o   = pick.idx;

endmodule

// File: rtl/excl_grant_arbiter.sv
// Round-robin arbiter driving three mutually-exclusive grant lines. A grant is
// held until the owner releases it or the hold watchdog fires.
module excl_grant_arbiter
    import excl_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD   = 64,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] release_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [1:0]         owner_o,
    output logic               busy_o,
    output logic               timeout_o,
    output logic               err_release_o
);

    if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_max_hold
        $error("excl_grant_arbiter: MAX_HOLD out of range");
    end
    if (GAP_CYCLES > 15) begin : g_bad_gap
        $error("excl_grant_arbiter: GAP_CYCLES out of range");
    end
    if ((64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cnt_w
        $error("excl_grant_arbiter: CNT_W too narrow for MAX_HOLD");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               timeout_q, timeout_d;
    logic               err_q, err_d;

    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic               own_rel;
    logic               wd_hit;

    excl_arb_rr_pick u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // grant_q is one-hot of the owner while in GRANT, so masking avoids
    // indexing release_i with the NO_OWNER code.
    assign own_rel = (state_q == GRANT) && ((release_i & grant_q) != '0);
    assign wd_hit  = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        timeout_d  = 1'b0;
        err_d      = (release_i & ((state_q == GRANT) ? ~grant_q : '1)) != '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    grant_d    = onehot3(pick_idx);
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (own_rel || wd_hit) begin
                    // Release takes priority over a coincident watchdog hit.
                    timeout_d  = !own_rel;
                    grant_d    = '0;
                    owner_d    = NO_OWNER;
                    rr_ptr_d   = rr_next(owner_q);
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = NO_OWNER;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= NO_OWNER;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
        end
    end

    assign grant_o       = grant_q;
    assign owner_o       = owner_q;
    assign busy_o        = (state_q != IDLE);
    assign timeout_o     = timeout_q;
    assign err_release_o = err_q;

endmodule
